// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller:
// pipeline control structs, controller state encoding and transfer-size codes.
package structures;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned SIZE_W = 2;

   // EX/MEM memory control: read/write strobes and requested transfer size.
   typedef struct packed {
      logic       read_en;
      logic       write_en;
      logic [2:0] xfer_size;
   } struct_MEM;

   // EX/MEM writeback control forwarded to MEM/WB.
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } struct_WB;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } mem_state_t;

   localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
   localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
   localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
   localparam logic [SIZE_W-1:0] SZ_D = 2'd3;

   // Sizes 4..7 are not encodable on the bus and collapse to a doubleword.
   function automatic logic [SIZE_W-1:0] clamp_size(input logic [2:0] xfer);
      return xfer[2] ? SZ_D : xfer[SIZE_W-1:0];
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller (master)
// and the data memory (slave).
interface mem_access_ctrl_if;
   import structures::*;

   logic              dmem_req;
   logic              dmem_we;
   logic [XLEN-1:0]   dmem_addr;
   logic [XLEN-1:0]   dmem_wdata;
   logic [SIZE_W-1:0] dmem_size;
   logic              dmem_ack;
   logic [XLEN-1:0]   dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_load_ext.sv
// Zero-extends raw 64-bit load data to the transfer size.
module mem_load_ext
   import structures::*;
(
   input  logic [XLEN-1:0]   i_data,
   input  logic [SIZE_W-1:0] i_size,
   output logic [XLEN-1:0]   o_data_c
);

   // Keep only the low bytes covered by the transfer.
   always_comb begin
      o_data_c = '0;
      case (i_size)
         SZ_B:    o_data_c = XLEN'(i_data[7:0]);
         SZ_H:    o_data_c = XLEN'(i_data[15:0]);
         SZ_W:    o_data_c = XLEN'(i_data[31:0]);
         default: o_data_c = i_data;
      endcase
   end

endmodule

// File: rtl/singleReg.sv
// One-bit register with synchronous active-high reset and load enable.
module singleReg (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   // Reset wins over load; otherwise capture i_d when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 1'b0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Issues one request per load/store,
// stalls the front of the pipeline until the memory acknowledges, and forwards
// writeback control/data to MEM/WB (bubbles while waiting).
// Optional build macro MEM_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES
// unacknowledged REQ cycles and raise a sticky dmem_err.
module mem_access_ctrl
   import structures::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  struct_MEM         mem_MEM,
   input  struct_WB          mem_WB,
   input  logic [XLEN-1:0]   mem_ALU_result,
   input  logic [XLEN-1:0]   mem_ALU_B,
   input  logic [REG_W-1:0]  mem_Rd,
   mem_access_ctrl_if.master bus,
   output logic              stall,
   output struct_WB          wb_WB,
   output logic [REG_W-1:0]  wb_Rd,
   output logic [XLEN-1:0]   wb_ALU_result,
   output logic [XLEN-1:0]   wb_mem_data,
   output logic              dmem_err
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("mem_access_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   logic              w_access;
   logic              w_load;
   logic              w_timeout;
   logic              r_state_q;
   mem_state_t        r_state;
   mem_state_t        w_state_d;
   logic              r_req;
   logic              r_we;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [SIZE_W-1:0] r_size;
   logic [XLEN-1:0]   w_ext;

   assign w_access = mem_MEM.read_en | mem_MEM.write_en;
   assign r_state  = mem_state_t'(r_state_q);

   singleReg u_state (
      .clk  (clk),
      .rst  (rst),
      .i_en (1'b1),
      .i_d  (w_state_d == REQ),
      .o_q  (r_state_q)
   );

   // Request strobe is high exactly while the controller sits in REQ.
   singleReg u_req (
      .clk  (clk),
      .rst  (rst),
      .i_en (1'b1),
      .i_d  (w_state_d == REQ),
      .o_q  (r_req)
   );

   mem_load_ext u_load_ext (
      .i_data   (bus.dmem_rdata),
      .i_size   (r_size),
      .o_data_c (w_ext)
   );

   // Next state, stall and writeback steering; everything idle while in reset.
   always_comb begin
      w_state_d   = r_state;
      w_load      = 1'b0;
      stall       = 1'b0;
      wb_WB       = '0;
      wb_mem_data = '0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  stall     = 1'b1;
                  w_load    = 1'b1;
                  w_state_d = REQ;
               end else begin
                  wb_WB = mem_WB;
               end
            end
            REQ: begin
               if (bus.dmem_ack) begin
                  wb_WB       = mem_WB;
                  wb_mem_data = r_we ? '0 : w_ext;
                  w_state_d   = IDLE;
               end else if (w_timeout) begin
                  w_state_d = IDLE;
               end else begin
                  stall = 1'b1;
               end
            end
            default: w_state_d = IDLE;
         endcase
      end
   end

   // Capture the bus payload on entry to REQ and hold it for the whole access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_size  <= '0;
      end else if (w_load) begin
         r_we    <= mem_MEM.write_en;
         r_addr  <= mem_ALU_result;
         r_wdata <= mem_ALU_B;
         r_size  <= clamp_size(mem_MEM.xfer_size);
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_err;

   // Abort on the last permitted unacknowledged REQ cycle.
   assign w_timeout = (r_state == REQ) && !bus.dmem_ack &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_cnt_d   = ((r_state == REQ) && !bus.dmem_ack && !w_timeout) ?
                      (r_cnt + CNT_W'(1)) : '0;

   for (genvar gi = 0; gi < int'(CNT_W); gi++) begin : g_cnt
      singleReg u_cnt_bit (
         .clk  (clk),
         .rst  (rst),
         .i_en (1'b1),
         .i_d  (w_cnt_d[gi]),
         .o_q  (r_cnt[gi])
      );
   end

   singleReg u_err (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_timeout),
      .i_d  (1'b1),
      .o_q  (r_err)
   );

   assign dmem_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign dmem_err  = 1'b0;
`endif

   assign bus.dmem_req   = r_req;
   assign bus.dmem_we    = r_we;
   assign bus.dmem_addr  = r_addr;
   assign bus.dmem_wdata = r_wdata;
   assign bus.dmem_size  = r_size;

   assign wb_Rd         = mem_Rd;
   assign wb_ALU_result = mem_ALU_result;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max REQ cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 Port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: mem_MEM  input  struct_MEM (5)  EX/MEM control: read_en, write_en, xfer_size[2:0] (0=1B, 1=2B, 2=4B, 3=8B).
REQ-005 Port: mem_WB  input  struct_WB (2)  EX/MEM writeback control: reg_write, mem_to_reg.
REQ-006 Port: mem_ALU_result  input  64  effective address / ALU result.
REQ-007 Port: mem_ALU_B  input  64  store data.
REQ-008 Port: mem_Rd  input  5  destination register.
REQ-009 Port: dmem_req / dmem_we  output  1 / 1  request strobe; 1=write.
REQ-010 Port: dmem_addr / dmem_wdata  output  64 / 64  address; store data.
REQ-011 Port: dmem_size  output  2  transfer size, xfer_size[1:0].
REQ-012 Port: dmem_ack / dmem_rdata  input  1 / 64  completion strobe; raw read data.
REQ-013 Port: stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational).
REQ-014 Port: wb_WB / wb_Rd  output  struct_WB / 5  to MEM/WB register.
REQ-015 Port: wb_ALU_result / wb_mem_data  output  64 / 64  to MEM/WB register.
REQ-016 Port: dmem_err  output  1  sticky timeout flag.

Function
REQ-017 States: IDLE, REQ; access = read_en | write_en.
REQ-018 IDLE & access: stall=1 same cycle; next edge -> REQ; dmem_req registered 1 from that edge.
REQ-019 IDLE & ~access: stall=0, no request, outputs pass through (zero added latency).
REQ-020 dmem_we, dmem_addr, dmem_wdata, dmem_size are registered at IDLE->REQ edge and held constant throughout REQ.
REQ-021 read_en & write_en both set: write performed, read ignored, wb_mem_data=0.
REQ-022 xfer_size 4-7: treated as 8B.
REQ-023 REQ & ~dmem_ack: stall=1, wb_WB forced to 0 (bubble).
REQ-024 REQ & dmem_ack: stall=0, wb_WB=mem_WB, wb_mem_data = dmem_rdata zero-extended from dmem_size (0 for writes); next edge -> IDLE, dmem_req=0.
REQ-025 Minimum access = 2 cycles (ack on first REQ cycle); back-to-back accesses re-enter REQ after one IDLE cycle.
REQ-026 dmem_ack while IDLE: ignored, no state change.
REQ-027 wb_Rd, wb_ALU_result always equal mem_Rd, mem_ALU_result; wb_mem_data=0 except REQ & dmem_ack.

Reset
REQ-028 rst at edge: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr/wdata/size=0, timeout counter=0, dmem_err=0.
REQ-029 rst mid-REQ: request abandoned, dmem_req low after that edge; late ack ignored.
REQ-030 While rst=1: stall=0, wb_WB=0.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN defined: counter increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES, stall=0 that cycle, wb_WB=0, wb_mem_data=0, next edge -> IDLE, dmem_req=0, dmem_err=1 (sticky until rst).
REQ-032 Macro undefined: REQ waits indefinitely; no counter; dmem_err tied 0.

Structure
REQ-033 struct_MEM, struct_WB, state enum mem_state_t, size constants SZ_B/SZ_H/SZ_W/SZ_D live in package structures.
REQ-034 Sub-module mem_load_ext: combinational zero-extend of 64-bit data by 2-bit size.
REQ-035 State, request and counter registers built from singleReg per bit with enable.

Verification
REQ-036 Load 8B addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF_CAFEF00D -> stall 4 cycles, wb_mem_data=0xDEADBEEF_CAFEF00D on ack cycle, wb_WB bubbles before.
REQ-037 Store 1B addr 0x7, ALU_B 0x1234 -> dmem_we=1, dmem_size=0, dmem_wdata=0x1234 held to ack, wb_mem_data=0.
REQ-038 Load 1B, rdata 0xFFFF_FFFF_FFFF_FF80 -> wb_mem_data=0x80.
REQ-039 Non-memory op (read_en=write_en=0) -> stall=0, dmem_req=0, outputs pass through same cycle.
REQ-040 rst asserted on 2nd REQ cycle, ack next cycle -> dmem_req=0 after edge, ack ignored, state IDLE.
REQ-041 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> abort after 4 REQ cycles, dmem_err=1 held until rst; without macro stall held 100+ cycles.
